vga_scanout: RTL and testbench

// - Display-side consumer of the double-buffered framebuffer: generates VGA timing and scans the read buffer.
// - Drives a linear pixel address into the framebuffer VGA read port and takes back 4-bit colour indices.
// - Maps each index through a 16-entry 12-bit RGB palette and drives VGA RGB plus hsync/vsync.
// - vga_vsync also feeds the framebuffer's buffer-swap logic.

---
 rtl/vga_scanout.sv | 146 ++++++++++++++
 tb/tb_vga_scanout.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/vga_scanout.sv
// vga_scanout: VGA timing generator and framebuffer scan-out.
// Presents a linear read address to the framebuffer, takes the colour index
// back one cycle later and maps it through a 16-entry 12-bit palette.
// Every output is registered; pins lag the counter position by 2 cycles.
// Build option: define VGA_PALETTE_WR_EN to make the palette writable
// through the pal_wr_* ports; otherwise the palette is a fixed grey ramp.
module vga_scanout #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33
) (
    input  logic        clock,
    input  logic        reset,
    output logic [18:0] fb_addr,
    input  logic [3:0]  fb_data,
    output logic        vga_hsync,
    output logic        vga_vsync,
    output logic [3:0]  vga_r,
    output logic [3:0]  vga_g,
    output logic [3:0]  vga_b
`ifdef VGA_PALETTE_WR_EN
    ,
    input  logic        pal_wr_en,
    input  logic [3:0]  pal_wr_idx,
    input  logic [11:0] pal_wr_rgb
`endif
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0]  H_LAST     = 10'(H_TOTAL - 1);
    localparam logic [9:0]  V_LAST     = 10'(V_TOTAL - 1);
    localparam logic [9:0]  H_ACT      = 10'(H_ACTIVE);
    localparam logic [9:0]  V_ACT      = 10'(V_ACTIVE);
    localparam logic [9:0]  H_ACT_LAST = 10'(H_ACTIVE - 1);
    localparam logic [9:0]  V_ACT_LAST = 10'(V_ACTIVE - 1);
    localparam logic [9:0]  HS_BEG     = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0]  HS_END     = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0]  VS_BEG     = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0]  VS_END     = 10'(V_ACTIVE + V_FP + V_SYNC);

    logic [9:0]  h_cnt;
    logic [9:0]  v_cnt;
    logic        h_wrap;
    logic        v_wrap;
    logic        active;
    logic        last_pixel;
    logic        hsync_now;
    logic        vsync_now;
    logic        active_d1;
    logic        hsync_d1;
    logic        vsync_d1;
    logic [11:0] lookup;

    // Decode the current counter position.
    always_comb begin
        h_wrap     = (h_cnt == H_LAST);
        v_wrap     = (v_cnt == V_LAST);
        active     = (h_cnt < H_ACT) && (v_cnt < V_ACT);
        last_pixel = (h_cnt == H_ACT_LAST) && (v_cnt == V_ACT_LAST);
        hsync_now  = !((h_cnt >= HS_BEG) && (h_cnt < HS_END));
        vsync_now  = !((v_cnt >= VS_BEG) && (v_cnt < VS_END));
    end

    // Horizontal and vertical position counters, both wrapping.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else begin
            if (h_wrap) begin
                h_cnt <= '0;
                v_cnt <= v_wrap ? '0 : v_cnt + 10'd1;
            end else begin
                h_cnt <= h_cnt + 10'd1;
            end
        end
    end

    // Linear address: steps on active pixels, parks on the last pixel of the
    // frame through vertical blanking, and rewinds to 0 for pixel (0,0).
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            fb_addr <= '0;
        end else if (h_wrap && v_wrap) begin
            fb_addr <= '0;
        end else if (active && !last_pixel) begin
            fb_addr <= fb_addr + 19'd1;
        end
    end

    // Delay active/sync by two stages to line up with the palette output.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            active_d1 <= 1'b0;
            hsync_d1  <= 1'b1;
            vsync_d1  <= 1'b1;
            vga_hsync <= 1'b1;
            vga_vsync <= 1'b1;
        end else begin
            active_d1 <= active;
            hsync_d1  <= hsync_now;
            vsync_d1  <= vsync_now;
            vga_hsync <= hsync_d1;
            vga_vsync <= vsync_d1;
        end
    end

`ifdef VGA_PALETTE_WR_EN
    logic [11:0] palette [16];

    // Writable palette; reset reloads the grey ramp.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 16; i++) begin
                palette[i] <= {4'(i), 4'(i), 4'(i)};
            end
        end else if (pal_wr_en) begin
            palette[pal_wr_idx] <= pal_wr_rgb;
        end
    end

    assign lookup = palette[fb_data];
`else
    // Fixed grey ramp: entry i is {i,i,i}.
    assign lookup = {fb_data, fb_data, fb_data};
`endif

    // Registered palette lookup; black outside the active region.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            {vga_r, vga_g, vga_b} <= '0;
        end else if (active_d1) begin
            {vga_r, vga_g, vga_b} <= lookup;
        end else begin
            {vga_r, vga_g, vga_b} <= '0;
        end
    end

endmodule

// File: tb/tb_vga_scanout.sv
// tb_vga_scanout: two instances (reduced timing so whole frames fit the run,
// and default 640x480 timing) scanning a random framebuffer, checked every
// cycle against a position-based reference model through a scoreboard queue.
module tb_vga_scanout;

    typedef struct {
        int ha, hfp, hs, hbp, va, vfp, vs, vbp;
    } tim_t;

    typedef struct packed {
        logic [18:0] addr;
        logic        hs;
        logic        vs;
        logic [11:0] rgb;
    } exp_t;

    localparam int REL    = 3;
    localparam int S_HTOT = 40 + 4 + 8 + 6;
    localparam int S_VTOT = 30 + 3 + 2 + 5;
    localparam int S_FRM  = S_HTOT * S_VTOT;
    localparam int RST_AT = REL + 2 * S_FRM + 20 * S_HTOT + 30;
    localparam int NCYC   = RST_AT + 3 + 2700;

    logic        clock;
    logic        reset;
    logic [18:0] fb_addr_s, fb_addr_f;
    logic [3:0]  fb_data_s, fb_data_f;
    logic        hs_s, vs_s, hs_f, vs_f;
    logic [3:0]  r_s, g_s, b_s, r_f, g_f, b_f;
`ifdef VGA_PALETTE_WR_EN
    logic        pal_wr_en;
    logic [3:0]  pal_wr_idx;
    logic [11:0] pal_wr_rgb;
`endif

    int n_checks = 0;
    int n_errors = 0;

    logic [3:0]  fbmem [4096];
    logic [11:0] pal_m [16];
    exp_t        q_s[$];
    exp_t        q_f[$];
    tim_t        tm_s, tm_f;

    vga_scanout #(
        .H_ACTIVE(40), .H_FP(4), .H_SYNC(8), .H_BP(6),
        .V_ACTIVE(30), .V_FP(3), .V_SYNC(2), .V_BP(5)
    ) dut_s (
        .clock(clock), .reset(reset),
        .fb_addr(fb_addr_s), .fb_data(fb_data_s),
        .vga_hsync(hs_s), .vga_vsync(vs_s),
        .vga_r(r_s), .vga_g(g_s), .vga_b(b_s)
`ifdef VGA_PALETTE_WR_EN
        , .pal_wr_en(pal_wr_en), .pal_wr_idx(pal_wr_idx), .pal_wr_rgb(pal_wr_rgb)
`endif
    );

    vga_scanout dut_f (
        .clock(clock), .reset(reset),
        .fb_addr(fb_addr_f), .fb_data(fb_data_f),
        .vga_hsync(hs_f), .vga_vsync(vs_f),
        .vga_r(r_f), .vga_g(g_f), .vga_b(b_f)
`ifdef VGA_PALETTE_WR_EN
        , .pal_wr_en(pal_wr_en), .pal_wr_idx(pal_wr_idx), .pal_wr_rgb(pal_wr_rgb)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, req);
        end
    endtask

    // Address the spec implies for position (h,v): the pixel's own address
    // while active, the next line's first pixel in horizontal blanking, and
    // the last pixel of the frame through vertical blanking.
    function automatic int exp_addr(input int h, input int v, input tim_t tm);
        if (v < tm.va && h < tm.ha) return v * tm.ha + h;
        if (v < tm.va - 1) return (v + 1) * tm.ha;
        return tm.va * tm.ha - 1;
    endfunction

    // Expected pins t cycles after reset release.
    function automatic exp_t model(input int t, input tim_t tm);
        exp_t e;
        int htot, frm, p, h, v;
        htot = tm.ha + tm.hfp + tm.hs + tm.hbp;
        frm  = htot * (tm.va + tm.vfp + tm.vs + tm.vbp);
        p = t % frm;
        h = p % htot;
        v = p / htot;
        e.addr = 19'(exp_addr(h, v, tm));
        if (t < 2) begin
            e.hs  = 1'b1;
            e.vs  = 1'b1;
            e.rgb = '0;
        end else begin
            p = (t - 2) % frm;
            h = p % htot;
            v = p / htot;
            e.hs = !(h >= tm.ha + tm.hfp && h < tm.ha + tm.hfp + tm.hs);
            e.vs = !(v >= tm.va + tm.vfp && v < tm.va + tm.vfp + tm.vs);
            if (h < tm.ha && v < tm.va) e.rgb = pal_m[fbmem[(v * tm.ha + h) % 4096]];
            else e.rgb = '0;
        end
        return e;
    endfunction

    // Stimulus: reset sequencing, framebuffer responses, palette writes,
    // and expected values pushed into the scoreboard each cycle.
    initial begin
        int t;
        bit was_rst;
        logic [18:0] prev_s, prev_f;
        bit pend;
        logic [3:0] pidx;
        logic [11:0] prgb;
        exp_t rst_e;

        tm_s = '{40, 4, 8, 6, 30, 3, 2, 5};
        tm_f = '{640, 16, 96, 48, 480, 10, 2, 33};
        for (int i = 0; i < 4096; i++) fbmem[i] = 4'($urandom);
        for (int i = 0; i < 16; i++) pal_m[i] = {4'(i), 4'(i), 4'(i)};
        rst_e.addr = '0;
        rst_e.hs   = 1'b1;
        rst_e.vs   = 1'b1;
        rst_e.rgb  = '0;
        t = 0;
        was_rst = 1'b1;
        prev_s = '0;
        prev_f = '0;
        pend = 1'b0;
        pidx = '0;
        prgb = '0;
        reset = 1'b1;
        fb_data_s = '0;
        fb_data_f = '0;
`ifdef VGA_PALETTE_WR_EN
        pal_wr_en = 1'b0;
        pal_wr_idx = '0;
        pal_wr_rgb = '0;
`endif
        for (int c = 0; c < NCYC; c++) begin
            @(posedge clock);
            #1;
            reset = (c < REL) || (c >= RST_AT && c < RST_AT + 3);
            if (reset || was_rst) t = 0;
            else t++;
            was_rst = reset;

            fb_data_s = fbmem[prev_s[11:0]];
            fb_data_f = fbmem[prev_f[11:0]];
            prev_s = fb_addr_s;
            prev_f = fb_addr_f;

            if (reset) begin
                q_s.push_back(rst_e);
                q_f.push_back(rst_e);
            end else begin
                q_s.push_back(model(t, tm_s));
                q_f.push_back(model(t, tm_f));
            end

            if (pend) pal_m[pidx] = prgb;
            pend = 1'b0;
            if (reset) for (int i = 0; i < 16; i++) pal_m[i] = {4'(i), 4'(i), 4'(i)};
`ifdef VGA_PALETTE_WR_EN
            pal_wr_en = 1'b0;
            if (!reset && $urandom_range(7) == 0) begin
                pidx = 4'($urandom);
                prgb = 12'($urandom);
                pend = 1'b1;
                pal_wr_en = 1'b1;
                pal_wr_idx = pidx;
                pal_wr_rgb = prgb;
            end
`endif
        end
        @(negedge clock);
        #1;
        check("small scoreboard drained", 32'(q_s.size()), 32'd0);
        check("full scoreboard drained", 32'(q_f.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Monitor: pops the expected response each cycle and compares the pins.
    initial begin
        exp_t e;
        int cyc;
        int last_fall;
        logic prev_vs;
        cyc = 0;
        last_fall = -1;
        prev_vs = 1'b1;
        forever begin
            @(negedge clock);
            cyc++;
            if (q_s.size() > 0) begin
                e = q_s.pop_front();
                check("small fb_addr", 32'(fb_addr_s), 32'(e.addr));
                check("small hsync", 32'(hs_s), 32'(e.hs));
                check("small vsync", 32'(vs_s), 32'(e.vs));
                check("small rgb", 32'({r_s, g_s, b_s}), 32'(e.rgb));
            end
            if (q_f.size() > 0) begin
                e = q_f.pop_front();
                check("full fb_addr", 32'(fb_addr_f), 32'(e.addr));
                check("full hsync", 32'(hs_f), 32'(e.hs));
                check("full vsync", 32'(vs_f), 32'(e.vs));
                check("full rgb", 32'({r_f, g_f, b_f}), 32'(e.rgb));
            end
            if (reset) begin
                last_fall = -1;
            end else if (prev_vs && !vs_s) begin
                if (last_fall >= 0) check("small frame period", 32'(cyc - last_fall), 32'(S_FRM));
                last_fall = cyc;
            end
            prev_vs = vs_s;
        end
    end

endmodule
